// File: rtl/acumulador_mac_pkg.sv
// acumulador_mac_pkg: shared FSM encoding and width/range helpers for the FIR MAC accumulator
package acumulador_mac_pkg;
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic int w_acc(int cant_bits, int guard);
    return 2 * cant_bits - 1 + guard;
  endfunction
  function automatic longint sat_max(int cant_bits);
    return (longint'(1) <<< (2 * cant_bits - 2)) - 1;
  endfunction
  function automatic longint sat_min(int cant_bits);
    return -(longint'(1) <<< (2 * cant_bits - 2));
  endfunction
endpackage

// File: rtl/acumulador_mac_sat_trunc.sv
// acumulador_mac_sat_trunc: narrows a wide signed sum by clamping or truncation, flagging out-of-range
module acumulador_mac_sat_trunc #(
  parameter int W_IN = 52,
  parameter int W_OUT = 49,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [W_IN-1:0]  sum_i,
  output logic [W_OUT-1:0] res_o,
  output logic             ovf_o
);
  // in range exactly when every bit above the output sign bit copies it
  assign ovf_o = !(&sum_i[W_IN-1:W_OUT-1] || ~|sum_i[W_IN-1:W_OUT-1]);
  assign res_o = (SAT_EN && ovf_o) ? (sum_i[W_IN-1] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}})
                                   : sum_i[W_OUT-1:0];
endmodule

// File: rtl/acumulador_mac.sv
// acumulador_mac: sums N_TAPS signed products per frame in a guarded accumulator and emits the narrowed result
module acumulador_mac
  import acumulador_mac_pkg::*;
#(
  parameter int cant_bits = 25,
  parameter int N_TAPS = 5,
  parameter int ACC_GUARD = 3,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   in_valid_i,
  input  logic [2*cant_bits-2:0] in_i,
  output logic [2*cant_bits-2:0] out_o,
  output logic                   out_valid_o,
  output logic                   ovf_o,
  output logic                   busy_o
);
  localparam int W = 2 * cant_bits - 1;
  localparam int W_ACC = w_acc(cant_bits, ACC_GUARD);
  localparam int CW = $clog2(N_TAPS + 1);
  if (N_TAPS < 1 || N_TAPS > 2 ** ACC_GUARD) begin : g_bad_taps
    $error("N_TAPS must lie in 1..2**ACC_GUARD so the accumulator cannot wrap");
  end
  state_t state_q, state_d;
  logic signed [W_ACC-1:0] acc_q, acc_d, in_ext, sum;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [W-1:0] out_q, out_d, sat_out;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d, sat_ovf, accept, done;
  // start restarts from an empty sum in either state, so the same product can be the first term
  always_comb begin
    in_ext = W_ACC'($signed(in_i));
    accept = in_valid_i && (start_i || state_q == ACCUM);
    sum = (start_i ? '0 : acc_q) + in_ext;
    cnt_inc = (start_i ? '0 : cnt_q) + CW'(1);
    done = accept && cnt_inc == CW'(N_TAPS);
    state_d = done ? IDLE : (start_i ? ACCUM : state_q);
    acc_d = done ? '0 : (accept ? sum : (start_i ? '0 : acc_q));
    cnt_d = done ? '0 : (accept ? cnt_inc : (start_i ? '0 : cnt_q));
    out_d = done ? sat_out : out_q;
    out_valid_d = done;
    ovf_d = done && sat_ovf;
  end
  acumulador_mac_sat_trunc #(
    .W_IN  (W_ACC),
    .W_OUT (W),
    .SAT_EN(SAT_EN)
  ) u_sat (
    .sum_i(sum),
    .res_o(sat_out),
    .ovf_o(sat_ovf)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_o = out_q;
  assign out_valid_o = out_valid_q;
  assign ovf_o = ovf_q;
  assign busy_o = state_q == ACCUM;
endmodule

// File: tb/tb_acumulador_mac.sv
// tb_acumulador_mac: table vectors, directed corner sequences and a random run against a frame-level sum model
module tb_acumulador_mac;
  localparam int W = 49;
  localparam longint Q = longint'(1) <<< 47;
  localparam longint H = longint'(1) <<< 48;
  localparam longint MAX = H - 1;
  localparam longint MIN = -H;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, s1 = 1'b0, v1 = 1'b0, s2 = 1'b0, v2 = 1'b0;
  logic [W-1:0] in_d = '0, in1 = '0, in2 = '0, out, out1, out2;
  logic out_valid, ovf, busy, ov1, ovf1, busy1, ov2, ovf2, busy2;
  int n_vec = 0, n_bad = 0;
  typedef struct {bit s; bit v; longint x; longint o; bit ov; bit ovf; bit busy;} vec_t;
  vec_t tbl[$];
  bit m_act, m_ov, m_ovf;
  longint m_sum, m_out;
  int m_cnt;
  always #5 clk = ~clk;
  acumulador_mac dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid), .in_i(in_d),
    .out_o(out), .out_valid_o(out_valid), .ovf_o(ovf), .busy_o(busy)
  );
  acumulador_mac #(.N_TAPS(1), .SAT_EN(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s1), .in_valid_i(v1), .in_i(in1),
    .out_o(out1), .out_valid_o(ov1), .ovf_o(ovf1), .busy_o(busy1)
  );
  acumulador_mac #(.SAT_EN(1'b0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s2), .in_valid_i(v2), .in_i(in2),
    .out_o(out2), .out_valid_o(ov2), .ovf_o(ovf2), .busy_o(busy2)
  );
  function automatic vec_t mk(bit s, bit v, longint x, longint o, bit ov, bit f, bit b);
    vec_t r;
    r.s = s; r.v = v; r.x = x; r.o = o; r.ov = ov; r.ovf = f; r.busy = b;
    return r;
  endfunction
  function automatic longint sx(logic [W-1:0] v);
    return longint'($signed(v));
  endfunction
  function automatic longint wrap(longint x);
    logic [W-1:0] t;
    t = x[W-1:0];
    return sx(t);
  endfunction
  task automatic chk(string nm, longint a, longint e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  task automatic chk_main(string nm, longint o, bit ov, bit f, bit b);
    chk({nm, ".out"}, sx(out), o);
    chk({nm, ".out_valid"}, longint'(out_valid), longint'(ov));
    chk({nm, ".ovf"}, longint'(ovf), longint'(f));
    chk({nm, ".busy"}, longint'(busy), longint'(b));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(bit s, bit v, longint x);
    start = s; in_valid = v; in_d = x[W-1:0];
    tick();
  endtask
  // frame-level reference: running sum of accepted products, clamped once the frame is full
  task automatic model(bit s, bit v, longint x);
    m_ov = 0; m_ovf = 0;
    if (s) begin m_act = 1; m_sum = 0; m_cnt = 0; end
    if (v && m_act) begin
      m_sum += x; m_cnt++;
      if (m_cnt == 5) begin
        m_ov = 1; m_act = 0;
        m_ovf = (m_sum > MAX) || (m_sum < MIN);
        m_out = m_sum > MAX ? MAX : (m_sum < MIN ? MIN : m_sum);
      end
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    bit pat[8];
    tick(); tick();
    chk_main("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(0, 1, i, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 5, 15, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 1, 99, 15, 0, 0, 0));
    tbl.push_back(mk(1, 1, Q, 15, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, Q, 15, 0, 0, 1));
    tbl.push_back(mk(0, 1, Q, MAX, 1, 1, 0));
    tbl.push_back(mk(1, 1, -H, MAX, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, -H, MAX, 0, 0, 1));
    tbl.push_back(mk(0, 1, -H, MIN, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, MIN, 0, 0, 1));
    pat = '{1, 0, 0, 1, 1, 0, 1, 1};
    k = 0;
    for (int i = 0; i < 8; i++) begin
      k += int'(pat[i]);
      tbl.push_back(k == 5 ? mk(0, 1, 10, 50, 1, 0, 0) : mk(0, pat[i], 10, MIN, 0, 0, 1));
    end
    tbl.push_back(mk(1, 0, 0, 50, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 7, 50, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 50, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 50, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 5, 1, 0, 0));
    tbl.push_back(mk(1, 1, 2, 5, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 2, 5, 0, 0, 1));
    tbl.push_back(mk(0, 1, 2, 10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 10, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].v, tbl[i].x);
      chk_main($sformatf("tbl%0d", i), tbl[i].o, tbl[i].ov, tbl[i].ovf, tbl[i].busy);
    end
    m_act = 0; m_out = 10;
    for (int i = 0; i < 400; i++) begin
      bit s, v;
      longint x;
      s = ($urandom_range(15) == 0);
      v = ($urandom_range(3) != 0);
      x = $urandom_range(1) ? (longint'({$urandom(), $urandom()}) >>> 15) : longint'($urandom_range(200)) - 100;
      model(s, v, x);
      drive(s, v, x);
      chk_main($sformatf("rand%0d", i), m_out, m_ov, m_ovf, m_act);
    end
    for (int i = 0; i < 5; i++) drive(i == 0, 1, Q);
    chk("pre_reset.out_valid", longint'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_main("async_reset_pulse", 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 1, 3);
    drive(0, 1, 3);
    chk("mid_frame.busy", longint'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_main("async_reset_mid", 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 7);
      chk_main("post_reset_idle", 0, 0, 0, 0);
    end
    drive(1, 0, 0);
    for (int i = 1; i <= 5; i++) drive(0, 1, i);
    chk_main("clean_frame", 15, 1, 0, 0);
    drive(0, 0, 0);
    chk_main("clean_frame_after", 15, 0, 0, 0);
    s1 = 1; v1 = 1; in1 = W'(-3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("n1.out", sx(out1), -3);
      chk("n1.out_valid", longint'(ov1), 1);
      chk("n1.busy", longint'(busy1), 0);
    end
    s1 = 0; v1 = 0;
    tick();
    chk("n1.idle_valid", longint'(ov1), 0);
    for (int f = 0; f < 3; f++) begin
      longint x, tot;
      x = f == 0 ? Q : (f == 1 ? -H : 3);
      tot = 0;
      for (int i = 0; i < 5; i++) begin
        s2 = (i == 0); v2 = 1; in2 = x[W-1:0]; tot += x;
        tick();
      end
      s2 = 0; v2 = 0;
      chk("trunc.out", sx(out2), wrap(tot));
      chk("trunc.ovf", longint'(ovf2), longint'((tot > MAX) || (tot < MIN)));
      chk("trunc.out_valid", longint'(ov2), 1);
    end
    drive(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
